opendap_swd_seq_detect: RTL and testbench



---
 rtl/opendap_swd_seq_detect_pkg.sv | 34 +++
 rtl/opendap_swd_seq_detect_if.sv | 25 ++
 rtl/opendap_swd_seq_detect_ones_counter.sv | 35 +++
 rtl/opendap_swd_seq_detect.sv | 158 +++++++++++++++
 tb/tb_opendap_swd_seq_detect.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/opendap_swd_seq_detect_pkg.sv
// Purpose: shared constants, match window sizing and FSM state types for the SWD sequence detector.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional feature macro: OPENDAP_ALERT_PREAMBLE_EN.
package opendap_swd_seq_detect_pkg;

  // Sequences as transmitted on the wire, LSB first.
  localparam logic [127:0] ALERT = 128'h19bc0ea2_e3ddafe9_86852d95_6209f392;
  localparam logic [7:0]   ACT   = 8'h1a;
  localparam logic [15:0]  DORM  = 16'he3bc;

  localparam int LINE_RESET_CYCLES_DEF = 50;

`ifdef OPENDAP_ALERT_PREAMBLE_EN
  // Alert must be preceded by eight ones; the oldest bits sit at the bottom.
  localparam int                SREG_W    = 136;
  localparam logic [SREG_W-1:0] ALERT_PAT = {ALERT, 8'hff};
`else
  localparam int                SREG_W    = 128;
  localparam logic [SREG_W-1:0] ALERT_PAT = ALERT;
`endif

  typedef enum logic [1:0] {
    ACT_HUNT = 2'd0,
    ACT_GAP  = 2'd1,
    ACT_CODE = 2'd2
  } act_state_t;

  typedef enum logic [1:0] {
    DRM_IDLE    = 2'd0,
    DRM_ARMED   = 2'd1,
    DRM_CAPTURE = 2'd2
  } drm_state_t;

endpackage

// File: rtl/opendap_swd_seq_detect_if.sv
// Purpose: bit-stream input and event pulses between the DP and the sequence detector.
// Latency: n/a (wiring only).
// Backpressure: none; one bit per swclk, pulses are fire-and-forget.
interface opendap_swd_seq_detect_if;
  logic swdi_reg;
  logic exit_dormant;
  logic enter_dormant;
  logic line_reset;

  // DP side: drives the sampled bit, consumes the event pulses.
  modport master (
    output swdi_reg,
    input  exit_dormant,
    input  enter_dormant,
    input  line_reset
  );

  // Detector side.
  modport slave (
    input  swdi_reg,
    output exit_dormant,
    output enter_dormant,
    output line_reset
  );
endinterface

// File: rtl/opendap_swd_seq_detect_ones_counter.sv
// Purpose: saturating run-of-ones counter with a single pulse when the run reaches THRESHOLD.
// Latency: reach_pulse registered, one cycle after the THRESHOLD-th one; hit is the same-cycle view.
// Backpressure: none; consumes one bit per cycle unconditionally.
module opendap_ones_counter #(
  parameter int THRESHOLD = 50
) (
  input  logic swclk,
  input  logic rst,
  input  logic din,
  output logic hit,
  output logic reach_pulse
);

  localparam logic [5:0] TH = 6'(THRESHOLD);

  logic [5:0] cnt;

  // Current bit is the one that brings the run up to the threshold.
  assign hit = din && (cnt == TH - 6'd1);

  // Count ones, hold at threshold, clear on any zero; register the reach event.
  always_ff @(posedge swclk) begin
    if (rst) begin
      cnt         <= 6'd0;
      reach_pulse <= 1'b0;
    end else begin
      reach_pulse <= hit;
      if (!din)
        cnt <= 6'd0;
      else if (cnt != TH)
        cnt <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/opendap_swd_seq_detect.sv
// Purpose: detects dormant-exit (alert+gap+activation), line reset and SWD-to-dormant in the SWDIO stream.
// Latency: each pulse is registered, high one cycle after the final bit of its sequence.
// Backpressure: none; free-running on every swclk. Optional: OPENDAP_ALERT_PREAMBLE_EN (8 ones before alert).
module opendap_swd_seq_detect
  import opendap_swd_seq_detect_pkg::*;
#(
  parameter int LINE_RESET_CYCLES = LINE_RESET_CYCLES_DEF
) (
  input  logic                      swclk,
  input  logic                      rst,
  opendap_swd_seq_detect_if.slave   sd
);

  logic din;
  assign din = sd.swdi_reg;

  // History of the previous SREG_W-1 bits, newest at the top. Together with
  // the live bit it forms the full match window, so a match is seen in the
  // same cycle as the final bit and the following FSM state starts on the
  // very next bit.
  logic [SREG_W-2:0] sreg;
  logic [SREG_W-1:0] win;
  logic              alert_hit;
  logic [7:0]        code8;
  logic [15:0]       code16;

  assign win       = {din, sreg};
  assign alert_hit = (win == ALERT_PAT);
  assign code8     = win[SREG_W-1 -: 8];
  assign code16    = win[SREG_W-1 -: 16];

  // Continuous LSB-first shift of the incoming stream.
  always_ff @(posedge swclk) begin
    if (rst) sreg <= '0;
    else     sreg <= win[SREG_W-1:1];
  end

  // Line reset detection.
  logic ones_hit;
  logic line_reset_q;

  opendap_ones_counter #(
    .THRESHOLD (LINE_RESET_CYCLES)
  ) u_ones (
    .swclk       (swclk),
    .rst         (rst),
    .din         (din),
    .hit         (ones_hit),
    .reach_pulse (line_reset_q)
  );

  // Activation FSM state.
  act_state_t act_state, act_nxt;
  logic [1:0] gap_ctr, gap_nxt;
  logic [2:0] abit_ctr, abit_nxt;
  logic       exit_nxt, exit_q;

  // Dormant FSM state.
  drm_state_t drm_state, drm_nxt;
  logic [3:0] dbit_ctr, dbit_nxt;
  logic       enter_nxt, enter_q;

  // Register both FSMs and their output pulses.
  always_ff @(posedge swclk) begin
    if (rst) begin
      act_state <= ACT_HUNT;
      gap_ctr   <= 2'd0;
      abit_ctr  <= 3'd0;
      exit_q    <= 1'b0;
      drm_state <= DRM_IDLE;
      dbit_ctr  <= 4'd0;
      enter_q   <= 1'b0;
    end else begin
      act_state <= act_nxt;
      gap_ctr   <= gap_nxt;
      abit_ctr  <= abit_nxt;
      exit_q    <= exit_nxt;
      drm_state <= drm_nxt;
      dbit_ctr  <= dbit_nxt;
      enter_q   <= enter_nxt;
    end
  end

  // Activation: alert, four zero gap bits, then the 8-bit activation code.
  always_comb begin
    act_nxt  = act_state;
    gap_nxt  = gap_ctr;
    abit_nxt = abit_ctr;
    exit_nxt = 1'b0;
    case (act_state)
      ACT_HUNT: begin
        if (alert_hit) begin
          act_nxt = ACT_GAP;
          gap_nxt = 2'd0;
        end
      end
      ACT_GAP: begin
        if (alert_hit) begin
          gap_nxt = 2'd0;
        end else if (din) begin
          act_nxt = ACT_HUNT;
        end else if (gap_ctr == 2'd3) begin
          act_nxt  = ACT_CODE;
          abit_nxt = 3'd0;
        end else begin
          gap_nxt = gap_ctr + 2'd1;
        end
      end
      ACT_CODE: begin
        if (alert_hit) begin
          act_nxt = ACT_GAP;
          gap_nxt = 2'd0;
        end else if (abit_ctr == 3'd7) begin
          exit_nxt = (code8 == ACT);
          act_nxt  = ACT_HUNT;
        end else begin
          abit_nxt = abit_ctr + 3'd1;
        end
      end
      default: act_nxt = ACT_HUNT;
    endcase
  end

  // Dormant entry: line reset arms, first zero starts a 16-bit capture.
  always_comb begin
    drm_nxt   = drm_state;
    dbit_nxt  = dbit_ctr;
    enter_nxt = 1'b0;
    case (drm_state)
      DRM_IDLE: begin
        if (ones_hit) drm_nxt = DRM_ARMED;
      end
      DRM_ARMED: begin
        // The opening zero is already bit 0 of the capture.
        if (!din) begin
          drm_nxt  = DRM_CAPTURE;
          dbit_nxt = 4'd1;
        end
      end
      DRM_CAPTURE: begin
        if (ones_hit) begin
          drm_nxt = DRM_ARMED;
        end else if (dbit_ctr == 4'd15) begin
          enter_nxt = (code16 == DORM);
          drm_nxt   = DRM_IDLE;
        end else begin
          dbit_nxt = dbit_ctr + 4'd1;
        end
      end
      default: drm_nxt = DRM_IDLE;
    endcase
  end

  assign sd.exit_dormant  = exit_q;
  assign sd.enter_dormant = enter_q;
  assign sd.line_reset    = line_reset_q;

endmodule

// File: tb/tb_opendap_swd_seq_detect.sv
// Purpose: directed, table-driven check of the SWD sequence detector pulses and their timing.
// Latency: pulse index expected equals the stream index of the sequence's final bit.
// Backpressure: n/a.
module tb_opendap_swd_seq_detect;
  import opendap_swd_seq_detect_pkg::*;

  logic swclk = 1'b0;
  logic rst   = 1'b1;

  always #5 swclk = ~swclk;

  opendap_swd_seq_detect_if sd ();

  opendap_swd_seq_detect #(
    .LINE_RESET_CYCLES (50)
  ) dut (
    .swclk (swclk),
    .rst   (rst),
    .sd    (sd)
  );

`ifdef OPENDAP_ALERT_PREAMBLE_EN
  localparam int PRE7_EXIT = -1;
  localparam int PRE0_EXIT = -1;
`else
  localparam int PRE7_EXIT = 146;
  localparam int PRE0_EXIT = 139;
`endif

  typedef struct {
    string       name;
    int          n_ones;
    bit          alert;
    logic [3:0]  gap;
    logic [7:0]  code;
    bit          dorm;
    logic [15:0] dcode;
    int          exp_line;
    int          exp_exit;
    int          exp_enter;
  } vec_t;

  vec_t tbl [11];

  int n_vec  = 0;
  int n_fail = 0;

  bit stream [$];
  int got_line [$];
  int got_exit [$];
  int got_enter [$];
  int e_line [$];
  int e_exit [$];
  int e_enter [$];

  task automatic add_ones(input int n);
    for (int k = 0; k < n; k++) stream.push_back(1'b1);
  endtask

  task automatic add_val(input logic [127:0] v, input int n);
    for (int k = 0; k < n; k++) stream.push_back(v[k]);
  endtask

  task automatic add_activation(input int pre_ones, input logic [3:0] gap, input logic [7:0] code);
    add_ones(pre_ones);
    add_val(ALERT, 128);
    add_val({124'd0, gap}, 4);
    add_val({120'd0, code}, 8);
  endtask

  task automatic check_bit(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic cmp_q(input string nm, input int got[$], input int exp[$]);
    n_vec++;
    if (got.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s pulse count: got %0d expected %0d (first got idx %0d)",
               nm, got.size(), exp.size(), (got.size() > 0) ? got[0] : -1);
    end else begin
      for (int k = 0; k < exp.size(); k++) begin
        n_vec++;
        if (got[k] != exp[k]) begin
          n_fail++;
          $display("FAIL %s pulse %0d index: got %0d expected %0d", nm, k, got[k], exp[k]);
        end
      end
    end
  endtask

  // Reset, play the stream (plus trailing zeros), record pulse indices.
  // rst_idx >= 0 asserts rst together with that bit.
  task automatic run_stream(input string nm, input int rst_idx);
    got_line.delete();
    got_exit.delete();
    got_enter.delete();
    for (int k = 0; k < 24; k++) stream.push_back(1'b0);
    rst = 1'b1;
    sd.swdi_reg = 1'b0;
    repeat (2) @(negedge swclk);
    check_bit({nm, " reset line_reset"},    sd.line_reset,    1'b0);
    check_bit({nm, " reset exit_dormant"},  sd.exit_dormant,  1'b0);
    check_bit({nm, " reset enter_dormant"}, sd.enter_dormant, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < stream.size(); i++) begin
      sd.swdi_reg = stream[i];
      rst = (i == rst_idx);
      @(negedge swclk);
      if (i == rst_idx) begin
        check_bit({nm, " rst-cycle line_reset"},    sd.line_reset,    1'b0);
        check_bit({nm, " rst-cycle exit_dormant"},  sd.exit_dormant,  1'b0);
        check_bit({nm, " rst-cycle enter_dormant"}, sd.enter_dormant, 1'b0);
      end
      if (sd.line_reset)    got_line.push_back(i);
      if (sd.exit_dormant)  got_exit.push_back(i);
      if (sd.enter_dormant) got_enter.push_back(i);
    end
    rst = 1'b0;
    stream.delete();
  endtask

  initial begin
    sd.swdi_reg = 1'b0;

    tbl[0]  = '{"lr50",     50,  1'b0, 4'h0,    8'h00, 1'b0, 16'h0000, 49, -1,        -1};
    tbl[1]  = '{"lr49",     49,  1'b0, 4'h0,    8'h00, 1'b0, 16'h0000, -1, -1,        -1};
    tbl[2]  = '{"lr200",    200, 1'b0, 4'h0,    8'h00, 1'b0, 16'h0000, 49, -1,        -1};
    tbl[3]  = '{"act_ok",   8,   1'b1, 4'h0,    8'h1a, 1'b0, 16'h0000, -1, 147,       -1};
    tbl[4]  = '{"act_bad",  8,   1'b1, 4'h0,    8'h1b, 1'b0, 16'h0000, -1, -1,        -1};
    tbl[5]  = '{"gap_one",  8,   1'b1, 4'b0100, 8'h1a, 1'b0, 16'h0000, -1, -1,        -1};
    tbl[6]  = '{"dorm_ok",  60,  1'b0, 4'h0,    8'h00, 1'b1, 16'he3bc, 49, -1,        75};
    tbl[7]  = '{"dorm_bad", 60,  1'b0, 4'h0,    8'h00, 1'b1, 16'he3bd, 49, -1,        -1};
    tbl[8]  = '{"dorm_50",  50,  1'b0, 4'h0,    8'h00, 1'b1, 16'he3bc, 49, -1,        65};
    tbl[9]  = '{"pre7",     7,   1'b1, 4'h0,    8'h1a, 1'b0, 16'h0000, -1, PRE7_EXIT, -1};
    tbl[10] = '{"pre0",     0,   1'b1, 4'h0,    8'h1a, 1'b0, 16'h0000, -1, PRE0_EXIT, -1};

    for (int t = 0; t < 11; t++) begin
      stream.delete();
      if (tbl[t].alert) add_activation(tbl[t].n_ones, tbl[t].gap, tbl[t].code);
      else              add_ones(tbl[t].n_ones);
      if (tbl[t].dorm)  add_val({112'd0, tbl[t].dcode}, 16);
      run_stream(tbl[t].name, -1);
      e_line.delete();  e_exit.delete();  e_enter.delete();
      if (tbl[t].exp_line  >= 0) e_line.push_back(tbl[t].exp_line);
      if (tbl[t].exp_exit  >= 0) e_exit.push_back(tbl[t].exp_exit);
      if (tbl[t].exp_enter >= 0) e_enter.push_back(tbl[t].exp_enter);
      cmp_q({tbl[t].name, " line_reset"},    got_line,  e_line);
      cmp_q({tbl[t].name, " exit_dormant"},  got_exit,  e_exit);
      cmp_q({tbl[t].name, " enter_dormant"}, got_enter, e_enter);
    end

    // Mixed: long ones run doubles as preamble; line reset and activation both fire.
    stream.delete();
    add_activation(60, 4'h0, 8'h1a);
    run_stream("mix", -1);
    e_line = {49};  e_exit = {199};  e_enter.delete();
    cmp_q("mix line_reset",    got_line,  e_line);
    cmp_q("mix exit_dormant",  got_exit,  e_exit);
    cmp_q("mix enter_dormant", got_enter, e_enter);

    // Back-to-back activations with no idle bits between them.
    stream.delete();
    add_activation(8, 4'h0, 8'h1a);
    add_activation(8, 4'h0, 8'h1a);
    run_stream("b2b_act", -1);
    e_exit = {147, 295};
    cmp_q("b2b_act exit_dormant", got_exit, e_exit);

    // Line reset, one zero, another line reset.
    stream.delete();
    add_ones(50);
    stream.push_back(1'b0);
    add_ones(50);
    run_stream("b2b_lr", -1);
    e_line = {49, 100};
    cmp_q("b2b_lr line_reset", got_line, e_line);

    // Reset lands on the 50th one: the pulse must not appear.
    stream.delete();
    add_ones(50);
    run_stream("rst_lr", 49);
    e_line.delete();
    cmp_q("rst_lr line_reset", got_line, e_line);

    // Reset at alert bit 100: the straddling activation is not detected.
    stream.delete();
    add_activation(8, 4'h0, 8'h1a);
    run_stream("rst_alert", 108);
    e_exit.delete();
    cmp_q("rst_alert exit_dormant", got_exit, e_exit);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
